pwm_duty_ramp_ctrl: RTL and testbench
=====================================

# pwm_duty_ramp_ctrl

Ramps the PWM duty-cycle register from its current value to a target in programmable steps, one step per PWM period tick. It also shares the single register-file write port between the SPI peripheral's write decoder and this ramp engine. It sits between the SPI register decoder and the PWM register bank inside the onboarding top, `tt_um_uwasic_onboarding_abdaal_sylani`.

## Interface
Parameters:
- `ADDR_W`, default 7: register address width.
- `DUTY_ADDR`, default 7'h04: address of the PWM duty-cycle register.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  one-cycle pulse that starts a ramp.
- `cfg_target`  in  8  target duty value.
- `cfg_step`  in  8  step magnitude per tick; 0 is treated as 1.
- `tick`  in  1  one-cycle pulse at each PWM period boundary.
- `spi_wr_valid`  in  1  SPI decoder write request.
- `spi_wr_addr`  in  ADDR_W  SPI write address.
- `spi_wr_data`  in  8  SPI write data.
- `reg_we`  out  1  register-bank write enable.
- `reg_addr`  out  ADDR_W  register-bank address.
- `reg_wdata`  out  8  register-bank write data.
- `duty_cur`  out  8  shadow of the duty register contents.
- `busy`  out  1  high while a ramp is active.
- `done`  out  1  one-cycle pulse when a ramp completes.

## Operation
- States:
  - IDLE.
  - WAIT_TICK: ramp active, waiting for `tick`.
  - PENDING: step computed, write port held by SPI.
- **SPI priority.** SPI always wins the write port. Each `spi_wr_valid` is forwarded unchanged on `reg_*` and is never stalled or dropped; there is no ready signal.
- **SPI write to the duty register.** Any forwarded SPI write with address `DUTY_ADDR` updates `duty_cur` to `spi_wr_data`. If a ramp is active, the ramp aborts: the state goes to IDLE, `busy` drops, `done` is not pulsed, and no pending ramp write is issued.
- **Starting a ramp (IDLE + `cfg_valid`).**
  - Latch `cfg_target` and `max(cfg_step,1)`.
  - If the target equals `duty_cur`: pulse `done` next cycle, issue no write, stay in IDLE.
  - Otherwise go to WAIT_TICK.
- `cfg_valid` is ignored while `busy`.
- **Step arithmetic.** Compute in 9 bits:
  - `next = min(duty_cur + step, target)` when ascending.
  - `next = max(duty_cur - step, target)` when descending.
  - No overshoot and no wrap past 0x00 or 0xFF.
- **WAIT_TICK + `tick`.**
  - Without `spi_wr_valid` in the same cycle: issue the ramp write (`DUTY_ADDR`, `next`) and update `duty_cur`.
  - With `spi_wr_valid`: forward the SPI write and go to PENDING, holding `next`.
- **PENDING.** Issue the ramp write in the first cycle without `spi_wr_valid`.
- **After a ramp write.**
  - If `next == target`: pulse `done`, return to IDLE.
  - Otherwise return to WAIT_TICK.
- `tick` pulses arriving in PENDING are dropped, not queued.
- **Reset** clears all state mid-ramp. No partial write is issued.

## Timing
- All outputs are registered.
- Reset values: `reg_we`=0, `reg_addr`=0, `reg_wdata`=0, `duty_cur`=0x00, `busy`=0, `done`=0; state IDLE.
- SPI write in cycle n appears on `reg_*` in cycle n+1; `duty_cur` is updated in n+1.
- Ramp write: `tick` in cycle n appears on `reg_*` in n+1 when the port is free. Each cycle of SPI contention adds one cycle.
- `busy` rises in the cycle after `cfg_valid`.
- `done` and the final ramp write are in the same cycle; `busy` falls in that same cycle.
- `reg_we` is high for exactly one cycle per write.

## Structure
- Shared package `onboarding_pkg` holds:
  - register address constants: `ADDR_OUT_7_0`=0x00, `ADDR_OUT_15_8`=0x01, `ADDR_PWM_EN_7_0`=0x02, `ADDR_PWM_EN_15_8`=0x03, `ADDR_PWM_DUTY`=0x04;
  - the ramp state enum.
- One combinational sub-module, `duty_step_calc`, takes (`cur`, `target`, `step`) and returns the saturating `next`.
- FSM, arbitration and output registers live in the top of this block.

## Test plan
- Reset, then `cfg_valid` with target 0x10, step 5, one `tick` every 4 cycles -> ramp writes to 0x04 with data 0x05, 0x0A, 0x0F, 0x10. `done` pulses with the 0x10 write; `busy` is low afterwards.
- `duty_cur` 0xF0, target 0xFF, step 0x20 -> a single write of 0xFF; no wrap to 0x10.
- Descend from 0x10 to target 0x02 with step 0 (treated as 1) -> 14 writes, 0x0F down to 0x02, then `done`.
- `spi_wr_valid` to 0x02 in the same cycle as `tick` -> SPI write appears first. The ramp write follows one cycle later, or later if SPI is held for several cycles. No write is lost.
- Mid-ramp SPI write of 0x80 to 0x04 -> `duty_cur`=0x80, `busy` low the next cycle, no `done`, no further ramp writes.
- Assert `rst` in the cycle after a `tick` while in PENDING -> no ramp write is issued; all outputs return to their reset values.

Source files
------------

// File: rtl/onboarding_pkg.sv
// rtl/onboarding_pkg.sv - shared register map and ramp state encoding
package onboarding_pkg;

  // Register bank address map
  localparam logic [6:0] ADDR_OUT_7_0     = 7'h00;
  localparam logic [6:0] ADDR_OUT_15_8    = 7'h01;
  localparam logic [6:0] ADDR_PWM_EN_7_0  = 7'h02;
  localparam logic [6:0] ADDR_PWM_EN_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  // Duty ramp engine states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_PENDING   = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/duty_step_calc.sv
// rtl/duty_step_calc.sv - saturating one-step move of the duty value toward a target
module duty_step_calc (
  input  logic [7:0] cur,
  input  logic [7:0] target,
  input  logic [7:0] step,
  output logic [7:0] next
);

  logic [8:0] sum9;
  logic [8:0] diff9;

  assign sum9  = {1'b0, cur} + {1'b0, step};
  assign diff9 = {1'b0, cur} - {1'b0, step};

  // Clamp at the target in the direction of travel; the 9th bit catches carry/borrow
  always_comb begin
    next = target;
    if (target > cur) begin
      if (sum9 < {1'b0, target}) next = sum9[7:0];
    end else if (target < cur) begin
      if (!diff9[8] && (diff9[7:0] > target)) next = diff9[7:0];
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - duty-cycle ramp engine sharing the register write port with SPI
module pwm_duty_ramp_ctrl
  import onboarding_pkg::*;
#(
  parameter int                ADDR_W    = 7,
  parameter logic [ADDR_W-1:0] DUTY_ADDR = 7'h04
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_target,
  input  logic [7:0]        cfg_step,
  input  logic              tick,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [7:0]        spi_wr_data,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic [7:0]        duty_cur,
  output logic              busy,
  output logic              done
);

  ramp_state_t       state_q, state_d;
  logic [7:0]        target_q, target_d;
  logic [7:0]        step_q, step_d;
  logic [7:0]        pend_q, pend_d;
  logic [7:0]        duty_d;
  logic              we_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        wdata_d;
  logic [7:0]        step_next;
  logic              ramp_wr;
  logic [7:0]        ramp_val;

  duty_step_calc u_calc (
    .cur    (duty_cur),
    .target (target_q),
    .step   (step_q),
    .next   (step_next)
  );

  // Arbitration and ramp sequencing; SPI always owns the port in the cycle it asks
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    step_d   = step_q;
    pend_d   = pend_q;
    duty_d   = duty_cur;
    we_d     = 1'b0;
    addr_d   = reg_addr;
    wdata_d  = reg_wdata;
    done_d   = 1'b0;
    ramp_wr  = 1'b0;
    ramp_val = 8'h00;

    if (spi_wr_valid) begin
      we_d    = 1'b1;
      addr_d  = spi_wr_addr;
      wdata_d = spi_wr_data;
      if (spi_wr_addr == DUTY_ADDR) begin
        // External duty write wins outright: abort any ramp, drop a same-cycle start
        duty_d  = spi_wr_data;
        state_d = ST_IDLE;
      end else if (state_q == ST_WAIT_TICK && tick) begin
        pend_d  = step_next;
        state_d = ST_PENDING;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            target_d = cfg_target;
            step_d   = (cfg_step == 8'd0) ? 8'd1 : cfg_step;
            if (cfg_target == duty_cur) done_d = 1'b1;
            else                        state_d = ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (tick) begin
            ramp_wr  = 1'b1;
            ramp_val = step_next;
          end
        end
        ST_PENDING: begin
          ramp_wr  = 1'b1;
          ramp_val = pend_q;
        end
        default: state_d = ST_IDLE;
      endcase

      if (ramp_wr) begin
        we_d    = 1'b1;
        addr_d  = DUTY_ADDR;
        wdata_d = ramp_val;
        duty_d  = ramp_val;
        if (ramp_val == target_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= 8'h00;
      step_q    <= 8'h01;
      pend_q    <= 8'h00;
      duty_cur  <= 8'h00;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      step_q    <= step_d;
      pend_q    <= pend_d;
      duty_cur  <= duty_d;
      reg_we    <= we_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - directed and randomized check against a behavioural model
module tb_pwm_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_target = 8'h00;
  logic [7:0] cfg_step = 8'h00;
  logic       tick = 1'b0;
  logic       spi_wr_valid = 1'b0;
  logic [6:0] spi_wr_addr = 7'h00;
  logic [7:0] spi_wr_data = 8'h00;
  logic       reg_we;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] duty_cur;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  pwm_duty_ramp_ctrl #(.ADDR_W(7), .DUTY_ADDR(7'h04)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_target   (cfg_target),
    .cfg_step     (cfg_step),
    .tick         (tick),
    .spi_wr_valid (spi_wr_valid),
    .spi_wr_addr  (spi_wr_addr),
    .spi_wr_data  (spi_wr_data),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .duty_cur     (duty_cur),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Reference model: ramp described as "a write per accepted tick, moving by step, clamped at target"
  int  m_duty, m_target, m_step, m_addr, m_wdata;
  bit  m_active, m_has_pending, m_we, m_done;
  int  m_pending_val;

  int  wr_log[$];
  int  done_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_next(input int cur, input int tgt, input int stp);
    if (tgt > cur) return (cur + stp > tgt) ? tgt : cur + stp;
    return (cur - stp < tgt) ? tgt : cur - stp;
  endfunction

  task automatic model_write(input int v);
    m_we = 1; m_addr = 4; m_wdata = v; m_duty = v;
    m_has_pending = 0;
    if (v == m_target) begin
      m_done = 1;
      m_active = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit cv, input int ct, input int cs,
                            input bit tk, input bit sv, input int sa, input int sd);
    m_we = 0; m_done = 0;
    if (r) begin
      m_duty = 0; m_addr = 0; m_wdata = 0;
      m_active = 0; m_has_pending = 0;
    end else if (sv) begin
      m_we = 1; m_addr = sa; m_wdata = sd;
      if (sa == 4) begin
        m_duty = sd;
        m_active = 0;
        m_has_pending = 0;
      end else if (m_active && !m_has_pending && tk) begin
        m_has_pending = 1;
        m_pending_val = ref_next(m_duty, m_target, m_step);
      end
    end else if (!m_active) begin
      if (cv) begin
        m_target = ct;
        m_step = (cs == 0) ? 1 : cs;
        if (ct == m_duty) m_done = 1;
        else              m_active = 1;
      end
    end else if (m_has_pending) begin
      model_write(m_pending_val);
    end else if (tk) begin
      model_write(ref_next(m_duty, m_target, m_step));
    end
  endtask

  // One clock: drive at the falling edge, compare everything at the next falling edge
  task automatic cyc(input bit r, input bit cv, input logic [7:0] ct, input logic [7:0] cs,
                     input bit tk, input bit sv, input logic [6:0] sa, input logic [7:0] sd);
    rst = r; cfg_valid = cv; cfg_target = ct; cfg_step = cs;
    tick = tk; spi_wr_valid = sv; spi_wr_addr = sa; spi_wr_data = sd;
    model_step(r, cv, ct, cs, tk, sv, sa, sd);
    @(posedge clk);
    @(negedge clk);
    check("reg_we", reg_we, m_we);
    check("reg_addr", reg_addr, m_addr);
    check("reg_wdata", reg_wdata, m_wdata);
    check("duty_cur", duty_cur, m_duty);
    check("busy", busy, m_active);
    check("done", done, m_done);
    if (reg_we) wr_log.push_back({reg_addr, reg_wdata});
    if (done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 8'h00, 0, 0, 7'h00, 8'h00);
  endtask
  task automatic tk_c();
    cyc(0, 0, 8'h00, 8'h00, 1, 0, 7'h00, 8'h00);
  endtask
  task automatic spi(input logic [6:0] a, input logic [7:0] d);
    cyc(0, 0, 8'h00, 8'h00, 0, 1, a, d);
  endtask
  task automatic cfg(input logic [7:0] t, input logic [7:0] s);
    cyc(0, 1, t, s, 0, 0, 7'h00, 8'h00);
  endtask
  task automatic clear_log();
    wr_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    m_target = 0; m_step = 1; m_pending_val = 0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 8'h00, 8'h00, 0, 0, 7'h00, 8'h00);
    check("rst_duty", duty_cur, 0);
    check("rst_busy", busy, 0);

    // Ascending ramp 0x00 -> 0x10 by 5, tick every 4 cycles
    cfg(8'h10, 8'd5);
    check("busy_after_cfg", busy, 1);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      idle(3);
      tk_c();
    end
    idle(2);
    check("asc_writes", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("asc_w0", wr_log[0], 32'h0405);
      check("asc_w1", wr_log[1], 32'h040A);
      check("asc_w2", wr_log[2], 32'h040F);
      check("asc_w3", wr_log[3], 32'h0410);
    end
    check("asc_done_cnt", done_cnt, 1);
    check("asc_busy_end", busy, 0);

    // Target equal to current: immediate done, no write
    clear_log();
    cfg(8'h10, 8'd3);
    check("eq_done", done, 1);
    idle(1);
    check("eq_writes", wr_log.size(), 0);

    // Saturation at 0xFF: no wrap
    spi(7'h04, 8'hF0);
    cfg(8'hFF, 8'h20);
    clear_log();
    idle(1);
    tk_c();
    idle(2);
    check("sat_writes", wr_log.size(), 1);
    if (wr_log.size() == 1) check("sat_w0", wr_log[0], 32'h04FF);
    check("sat_done_cnt", done_cnt, 1);

    // Descend 0x10 -> 0x02 with step 0 treated as 1
    spi(7'h04, 8'h10);
    cfg(8'h02, 8'h00);
    clear_log();
    for (int i = 0; i < 14; i++) begin
      idle(1);
      tk_c();
    end
    idle(2);
    check("desc_writes", wr_log.size(), 14);
    if (wr_log.size() == 14) begin
      check("desc_first", wr_log[0], 32'h040F);
      check("desc_last", wr_log[13], 32'h0402);
    end
    check("desc_done_cnt", done_cnt, 1);

    // SPI contention on the tick cycle, held for three cycles
    cfg(8'h40, 8'h10);
    clear_log();
    cyc(0, 0, 8'h00, 8'h00, 1, 1, 7'h02, 8'hAA);
    cyc(0, 0, 8'h00, 8'h00, 1, 1, 7'h02, 8'hBB);
    spi(7'h02, 8'hCC);
    idle(2);
    check("cont_writes", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      check("cont_spi0", wr_log[0], 32'h02AA);
      check("cont_ramp", wr_log[3], 32'h0412);
    end

    // Mid-ramp abort by SPI write to the duty register
    tk_c();
    spi(7'h04, 8'h80);
    check("abort_duty", duty_cur, 8'h80);
    check("abort_busy", busy, 0);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      tk_c();
    end
    check("abort_writes", wr_log.size(), 0);
    check("abort_done_cnt", done_cnt, 0);

    // Reset while a ramp write is pending
    cfg(8'h10, 8'd1);
    idle(1);
    cyc(0, 0, 8'h00, 8'h00, 1, 1, 7'h01, 8'h55);
    clear_log();
    cyc(1, 0, 8'h00, 8'h00, 0, 0, 7'h00, 8'h00);
    check("prst_we", reg_we, 0);
    check("prst_wdata", reg_wdata, 0);
    check("prst_duty", duty_cur, 0);
    idle(3);
    check("prst_writes", wr_log.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, cv, tk, sv;
      logic [7:0] ct, cs, sd;
      logic [6:0] sa;
      r  = ($urandom_range(0, 299) == 0);
      cv = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 5) == 0);
      ct = 8'($urandom);
      cs = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 64));
      sa = 7'($urandom_range(0, 5));
      sd = 8'($urandom);
      cyc(r, cv, ct, cs, tk, sv, sa, sd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
